tank_ai_ctrl: RTL and testbench
===============================

// Module: tank_ai_ctrl
// PURPOSE
// Autonomous driver for an enemy tank. Sits directly upstream of the tank datapath and generates its
// tank_move_i / tank_shoot_i. Wanders in pseudo-random directions, turns when its position stalls
// (wall collision), and turns toward and fires at the player when row/column aligned.
// PARAMETERS
// LFSR_SEED        16'hACE1  LFSR start value; 0 is replaced by 16'h0001
// DIR_INIT         4'b0001   initial heading (one-hot: 0001 down, 0010 up, 0100 right, 1000 left)
// MOVE_FRAMES_MIN  8'd32     minimum frames per straight run
// MOVE_FRAMES_MASK 8'h3F     mask applied to LFSR[7:0], added to MOVE_FRAMES_MIN
// STUCK_FRAMES     4'd8      consecutive frames with unchanged x,y before a forced turn
// SHOOT_PERIOD     8'd90     cooldown frames between shots
// ALIGN_TOL        10'd8     |dx| or |dy| below this counts as aligned
// AIM_FRAMES       2'd2      frames spent driving toward target before firing
// PORTS
// clk_i          in   1   pixel clock
// reset_tank     in   1   async active-high reset (system reset OR revive)
// frame_tick_i   in   1   one-clk_i pulse per frame
// enable_i       in   1   AI enabled
// tank_die_i     in   1   controlled tank is dead
// tank_x_i       in  10   controlled tank upper-left x
// tank_y_i       in  10   controlled tank upper-left y
// target_x_i     in  10   player tank upper-left x
// target_y_i     in  10   player tank upper-left y
// tank_move_o    out  4   one-hot move request, 0 = stand still
// tank_shoot_o   out  1   fire request (level, high exactly one frame)
// ai_state_o     out  2   current state, for debug
// BEHAVIOUR
// - All registers clocked by clk_i; reset_tank is asynchronous, active-high: reset reset_tank, asynchronous, active-high; clock clk_i.
// - Reset values: tank_move_o=0, tank_shoot_o=0, state=IDLE, dir=DIR_INIT, blocked=0, cooldown=SHOOT_PERIOD, lfsr=seed.
// - Outputs are registered; one clk_i latency from state change to output.
// - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11, advances every clk_i in all states.
// - IDLE: move=0, shoot=0. Exits to TURN when enable_i && !tank_die_i.
// - TURN (exactly 1 clk): dir = onehot(lfsr[1:0]); if dir==blocked, rotate clockwise
//   (up->right->down->left->up). move_cnt = MOVE_FRAMES_MIN + (lfsr[7:0] & MASK), 8-bit, saturating at 255.
//   Clear stuck_cnt, sample last_xy=tank_x/y. -> MOVE.
// - MOVE: move=dir. On frame_tick_i: move_cnt--; stuck_cnt++ if {x,y}==last_xy, else clear; update last_xy.
//   Exit priority on the same tick: stuck_cnt reaches STUCK_FRAMES -> TURN, blocked=dir;
//   else move_cnt hits 0 -> TURN, blocked=0; else aligned && cooldown==0 -> AIM.
// - Aligned: |tank_x-target_x|<ALIGN_TOL -> aim_dir = down if target_y>tank_y else up;
//   else |tank_y-target_y|<ALIGN_TOL -> right if target_x>tank_x else left. Vertical wins if both.
//   Absolute difference via 10-bit unsigned compare-and-subtract; no wrap.
// - AIM: move=aim_dir for AIM_FRAMES ticks (tank updates its heading only when moving), then
//   move=0, shoot=1 for one frame; on the next tick shoot=0, cooldown=SHOOT_PERIOD, dir=aim_dir,
//   -> MOVE with remaining move_cnt preserved.
// - Cooldown decrements on each tick in non-IDLE states and saturates at 0; holds in IDLE.
// - Ticks arriving while in TURN are ignored, except by cooldown.
// - From any state, tank_die_i or !enable_i -> IDLE next clk; move and shoot are 0 on that clk.
// - Reset mid-AIM or mid-shoot: shoot drops immediately (async). The shoot low->high edge occurs at most once per AIM.
// STRUCTURE
// - tank_pkg: DIR_DOWN/UP/RIGHT/LEFT localparams, ai_state_t enum {IDLE,TURN,MOVE,AIM},
//   function rot_cw(dir). Also used by tank datapath and map logic.
// - Sub-module tank_lfsr (16-bit Galois, seed parameter, zero-seed guard); the rest is a single FSM.
// TESTING
// - Reset, enable=1, die=0 -> IDLE, TURN, MOVE within 2 clk; move one-hot; move_cnt in [32,95].
// - Hold tank_x/y constant in MOVE -> TURN on 8th tick; new dir != old dir; blocked clears on the next expiry.
// - tank=(100,100), target=(104,300), cooldown=0 -> AIM; move=0001 for 2 ticks, shoot=1 for exactly 1 frame, cooldown=90.
// - target=(300,103) -> aim_dir=0100; target=(20,103) -> 1000; both axes aligned -> vertical dir.
// - Assert tank_die_i mid-AIM -> move=0, shoot=0 next clk, IDLE; release -> TURN; no extra shoot edge.
// - Stuck and expiry on the same tick -> blocked=dir; async reset mid-MOVE -> all outputs 0 immediately.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank definitions: heading encodings, AI state encoding and small helpers
// used by the AI controller, the tank datapath and the map logic.
package tank_pkg;

  localparam logic [3:0] DIR_DOWN  = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    MOVE = 2'd2,
    AIM  = 2'd3
  } ai_state_t;

  // Clockwise rotation: up -> right -> down -> left -> up.
  function automatic logic [3:0] rot_cw(input logic [3:0] dir);
    case (dir)
      DIR_UP:    return DIR_RIGHT;
      DIR_RIGHT: return DIR_DOWN;
      DIR_DOWN:  return DIR_LEFT;
      DIR_LEFT:  return DIR_UP;
      default:   return dir;
    endcase
  endfunction

  // Unsigned distance without wrap-around.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/tank_ai_ctrl_if.sv
// Control bundle between the tank AI and its environment (frame timing, positions,
// move/shoot requests). slave = the AI, master = whatever drives and observes it.
interface tank_ai_ctrl_if;

  logic       frame_tick_i;
  logic       enable_i;
  logic       tank_die_i;
  logic [9:0] tank_x_i;
  logic [9:0] tank_y_i;
  logic [9:0] target_x_i;
  logic [9:0] target_y_i;
  logic [3:0] tank_move_o;
  logic       tank_shoot_o;
  logic [1:0] ai_state_o;

  modport slave (
    input  frame_tick_i, enable_i, tank_die_i,
    input  tank_x_i, tank_y_i, target_x_i, target_y_i,
    output tank_move_o, tank_shoot_o, ai_state_o
  );

  modport master (
    output frame_tick_i, enable_i, tank_die_i,
    output tank_x_i, tank_y_i, target_x_i, target_y_i,
    input  tank_move_o, tank_shoot_o, ai_state_o
  );

endinterface

// File: rtl/tank_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11), free-running every clock.
// Only the low byte is consumed by the AI, so only that is exported.
module tank_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       reset_tank,
  output logic [7:0] rnd_o
);

  // An all-zero state would lock the register up forever.
  localparam logic [15:0] SEED_SAFE = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS      = 16'hB400;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_tank) begin
    if (reset_tank) lfsr_q <= SEED_SAFE;
    else            lfsr_q <= lfsr_d;
  end

  assign rnd_o = lfsr_q[7:0];

endmodule

// File: rtl/tank_ai_ctrl.sv
// Enemy tank autopilot: wanders in random headings, turns away from walls it is stuck
// against, and swings toward and fires at the player when it lines up on a row/column.
module tank_ai_ctrl
  import tank_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED        = 16'hACE1,
  parameter logic [3:0]  DIR_INIT         = 4'b0001,
  parameter logic [7:0]  MOVE_FRAMES_MIN  = 8'd32,
  parameter logic [7:0]  MOVE_FRAMES_MASK = 8'h3F,
  parameter logic [3:0]  STUCK_FRAMES     = 4'd8,
  parameter logic [7:0]  SHOOT_PERIOD     = 8'd90,
  parameter logic [9:0]  ALIGN_TOL        = 10'd8,
  parameter logic [1:0]  AIM_FRAMES       = 2'd2
) (
  input  logic            clk_i,
  input  logic            reset_tank,
  tank_ai_ctrl_if.slave   bus
);

  logic [7:0] rnd;

  tank_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i      (clk_i),
    .reset_tank (reset_tank),
    .rnd_o      (rnd)
  );

  ai_state_t   state_q;
  logic [3:0]  dir_q, blocked_q, aim_dir_q, move_q;
  logic        shoot_q;
  logic [7:0]  cooldown_q, move_cnt_q;
  logic [3:0]  stuck_cnt_q;
  logic [19:0] last_xy_q;
  logic [1:0]  aim_cnt_q;

  logic [3:0]  turn_raw, turn_dir, aim_dir;
  logic [8:0]  run_sum;
  logic [7:0]  run_len, move_cnt_nxt, cooldown_nxt;
  logic [9:0]  dx, dy;
  logic        aligned, aim_done;
  logic [3:0]  stuck_nxt;
  logic [19:0] cur_xy;

  // NOTE: every always_comb output gets a value up front so no path can infer a latch.
  always_comb begin
    turn_raw = DIR_DOWN << rnd[1:0];
    turn_dir = (turn_raw == blocked_q) ? rot_cw(turn_raw) : turn_raw;
    run_sum  = {1'b0, MOVE_FRAMES_MIN} + {1'b0, rnd & MOVE_FRAMES_MASK};
    run_len  = run_sum[8] ? 8'hFF : run_sum[7:0];

    cur_xy       = {bus.tank_x_i, bus.tank_y_i};
    stuck_nxt    = (cur_xy == last_xy_q) ? stuck_cnt_q + 4'd1 : 4'd0;
    move_cnt_nxt = (move_cnt_q == 8'd0) ? 8'd0 : move_cnt_q - 8'd1;
    cooldown_nxt = (cooldown_q == 8'd0) ? 8'd0 : cooldown_q - 8'd1;
    aim_done     = ({1'b0, aim_cnt_q} + 3'd1) >= {1'b0, AIM_FRAMES};

    // Column alignment takes precedence: shooting vertically when both match.
    dx      = abs_diff(bus.tank_x_i, bus.target_x_i);
    dy      = abs_diff(bus.tank_y_i, bus.target_y_i);
    aligned = 1'b0;
    aim_dir = 4'b0000;
    if (dx < ALIGN_TOL) begin
      aligned = 1'b1;
      aim_dir = (bus.target_y_i > bus.tank_y_i) ? DIR_DOWN : DIR_UP;
    end else if (dy < ALIGN_TOL) begin
      aligned = 1'b1;
      aim_dir = (bus.target_x_i > bus.tank_x_i) ? DIR_RIGHT : DIR_LEFT;
    end
  end

  // NOTE: every control register is reset; there is no storage array here that could skip it.
  always_ff @(posedge clk_i or posedge reset_tank) begin
    if (reset_tank) begin
      state_q     <= IDLE;
      dir_q       <= DIR_INIT;
      blocked_q   <= 4'b0000;
      aim_dir_q   <= 4'b0000;
      cooldown_q  <= SHOOT_PERIOD;
      move_cnt_q  <= 8'd0;
      stuck_cnt_q <= 4'd0;
      last_xy_q   <= 20'd0;
      aim_cnt_q   <= 2'd0;
      move_q      <= 4'b0000;
      shoot_q     <= 1'b0;
    end else begin
      if (bus.frame_tick_i && state_q != IDLE) cooldown_q <= cooldown_nxt;

      if (bus.tank_die_i || !bus.enable_i) begin
        state_q <= IDLE;
        move_q  <= 4'b0000;
        shoot_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            move_q  <= 4'b0000;
            shoot_q <= 1'b0;
            state_q <= TURN;
          end
          TURN: begin
            dir_q       <= turn_dir;
            move_cnt_q  <= run_len;
            stuck_cnt_q <= 4'd0;
            last_xy_q   <= cur_xy;
            move_q      <= turn_dir;
            state_q     <= MOVE;
          end
          MOVE: begin
            if (bus.frame_tick_i) begin
              move_cnt_q  <= move_cnt_nxt;
              stuck_cnt_q <= stuck_nxt;
              last_xy_q   <= cur_xy;
              if (stuck_nxt == STUCK_FRAMES) begin
                blocked_q <= dir_q;
                move_q    <= 4'b0000;
                state_q   <= TURN;
              end else if (move_cnt_nxt == 8'd0) begin
                blocked_q <= 4'b0000;
                move_q    <= 4'b0000;
                state_q   <= TURN;
              end else if (aligned && cooldown_q == 8'd0) begin
                aim_dir_q <= aim_dir;
                aim_cnt_q <= 2'd0;
                move_q    <= aim_dir;
                state_q   <= AIM;
              end
            end
          end
          AIM: begin
            // Drive toward the target first so the tank's heading turns, then fire.
            if (bus.frame_tick_i) begin
              if (shoot_q) begin
                shoot_q    <= 1'b0;
                cooldown_q <= SHOOT_PERIOD;
                dir_q      <= aim_dir_q;
                move_q     <= aim_dir_q;
                state_q    <= MOVE;
              end else if (aim_done) begin
                move_q  <= 4'b0000;
                shoot_q <= 1'b1;
              end else begin
                aim_cnt_q <= aim_cnt_q + 2'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.tank_move_o  = move_q;
  assign bus.tank_shoot_o = shoot_q;
  assign bus.ai_state_o   = state_q;

endmodule

// File: tb/tb_tank_ai_ctrl.sv
// Directed bench for tank_ai_ctrl: start-up, wall/expiry turns, aiming in all
// alignments, cooldown, death/disable and async reset behaviour.
module tb_tank_ai_ctrl;
  import tank_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  int   shots = 0;
  bit   xi = 1'b0;

  tank_ai_ctrl_if bus ();

  tank_ai_ctrl dut (
    .clk_i      (clk),
    .reset_tank (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge bus.tank_shoot_o) shots++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame tick lasting exactly one posedge; returns at the negedge after it.
  task automatic tick_xy(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    bus.tank_x_i     = x;
    bus.tank_y_i     = y;
    bus.frame_tick_i = 1'b1;
    @(negedge clk);
    bus.frame_tick_i = 1'b0;
  endtask

  // Tick while jiggling x between 100 and 101 so the tank never looks stuck.
  task automatic tick_alt();
    xi = ~xi;
    tick_xy(xi ? 10'd101 : 10'd100, 10'd100);
  endtask

  task automatic wait_aim(input logic [3:0] exp_dir, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int k = 0; k < 130 && !seen; k++) begin
      tick_alt();
      n++;
      if (bus.ai_state_o == AIM) seen = 1'b1;
    end
    check({tag, " reached"}, 32'(seen), 32'd1);
    check({tag, " cooldown held"}, 32'(n >= 90), 32'd1);
    check({tag, " aim dir"}, 32'(bus.tank_move_o), 32'(exp_dir));
  endtask

  task automatic finish_aim(input logic [3:0] exp_dir, input string tag);
    int s0;
    s0 = shots;
    tick_alt();
    check({tag, " aim2 move"}, 32'(bus.tank_move_o), 32'(exp_dir));
    tick_alt();
    check({tag, " fire shoot"}, 32'(bus.tank_shoot_o), 32'd1);
    check({tag, " fire move"}, 32'(bus.tank_move_o), 32'd0);
    tick_alt();
    check({tag, " done shoot"}, 32'(bus.tank_shoot_o), 32'd0);
    check({tag, " done state"}, 32'(bus.ai_state_o), 32'(MOVE));
    check({tag, " done dir"}, 32'(bus.tank_move_o), 32'(exp_dir));
    check({tag, " one edge"}, 32'(shots - s0), 32'd1);
  endtask

  // Tick with fresh positions each frame until the FSM leaves MOVE; returns frames used.
  task automatic run_until_turn(input int base, input int hold_from, output int n);
    n = 0;
    for (int k = 1; k <= 110; k++) begin
      tick_xy(10'((k < hold_from) ? base + k - 1 : base + hold_from - 1), 10'd50);
      if (bus.ai_state_o != MOVE) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n, s0;
    logic [3:0] d_prev;

    bus.frame_tick_i = 1'b0;
    bus.enable_i     = 1'b1;
    bus.tank_die_i   = 1'b0;
    bus.tank_x_i     = 10'd200;
    bus.tank_y_i     = 10'd50;
    bus.target_x_i   = 10'd600;
    bus.target_y_i   = 10'd600;

    #12;
    check("reset move", 32'(bus.tank_move_o), 32'd0);
    check("reset shoot", 32'(bus.tank_shoot_o), 32'd0);
    check("reset state", 32'(bus.ai_state_o), 32'(IDLE));

    // Seed ACE1 steps once to E270: heading 0001, run length 32 + 0x30 = 80.
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("start turn", 32'(bus.ai_state_o), 32'(TURN));
    check("start turn move", 32'(bus.tank_move_o), 32'd0);
    @(negedge clk);
    check("start move", 32'(bus.ai_state_o), 32'(MOVE));
    check("start dir", 32'(bus.tank_move_o), 32'(DIR_DOWN));

    // Position freezes from frame 72, so stuck and expiry coincide on frame 80.
    run_until_turn(200, 72, n);
    check("coincide frame", 32'(n), 32'd80);
    @(negedge clk);
    check("coincide move", 32'(bus.ai_state_o), 32'(MOVE));
    check("coincide onehot", 32'($onehot(bus.tank_move_o)), 32'd1);
    check("coincide new dir", 32'(bus.tank_move_o != DIR_DOWN), 32'd1);
    d_prev = bus.tank_move_o;

    // Still frozen: the eighth unchanged frame forces a turn away.
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick_xy(10'd271, 10'd50);
      if (bus.ai_state_o != MOVE) begin
        n = k;
        break;
      end
    end
    check("stuck frame", 32'(n), 32'd8);
    @(negedge clk);
    check("stuck onehot", 32'($onehot(bus.tank_move_o)), 32'd1);
    check("stuck new dir", 32'(bus.tank_move_o != d_prev), 32'd1);

    // Cooldown was 90-80-8 = 2; drain it, then line up under the player.
    for (int k = 0; k < 4; k++) tick_alt();
    bus.target_x_i = 10'd104;
    bus.target_y_i = 10'd300;
    tick_alt();
    check("aim enter state", 32'(bus.ai_state_o), 32'(AIM));
    check("aim enter dir", 32'(bus.tank_move_o), 32'(DIR_DOWN));
    check("aim enter shoot", 32'(bus.tank_shoot_o), 32'd0);
    s0 = shots;
    tick_alt();
    check("aim1 move", 32'(bus.tank_move_o), 32'(DIR_DOWN));
    check("aim1 shoot", 32'(bus.tank_shoot_o), 32'd0);
    tick_alt();
    check("fire shoot", 32'(bus.tank_shoot_o), 32'd1);
    check("fire move", 32'(bus.tank_move_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("fire mid-frame", 32'(bus.tank_shoot_o), 32'd1);
    tick_alt();
    check("fire done", 32'(bus.tank_shoot_o), 32'd0);
    check("fire done state", 32'(bus.ai_state_o), 32'(MOVE));
    check("fire done dir", 32'(bus.tank_move_o), 32'(DIR_DOWN));
    check("fire edges", 32'(shots - s0), 32'd1);

    bus.target_x_i = 10'd300;
    bus.target_y_i = 10'd103;
    wait_aim(DIR_RIGHT, "right");
    finish_aim(DIR_RIGHT, "right");

    bus.target_x_i = 10'd20;
    wait_aim(DIR_LEFT, "left");
    finish_aim(DIR_LEFT, "left");

    bus.target_x_i = 10'd104;
    bus.target_y_i = 10'd97;
    wait_aim(DIR_UP, "both");

    // Kill the tank while it is firing.
    tick_alt();
    tick_alt();
    check("die pre shoot", 32'(bus.tank_shoot_o), 32'd1);
    s0 = shots;
    @(negedge clk) bus.tank_die_i = 1'b1;
    bus.target_x_i = 10'd600;
    bus.target_y_i = 10'd600;
    @(negedge clk);
    check("die state", 32'(bus.ai_state_o), 32'(IDLE));
    check("die move", 32'(bus.tank_move_o), 32'd0);
    check("die shoot", 32'(bus.tank_shoot_o), 32'd0);
    bus.tank_die_i = 1'b0;
    @(negedge clk);
    check("revive turn", 32'(bus.ai_state_o), 32'(TURN));
    @(negedge clk);
    check("revive move", 32'(bus.ai_state_o), 32'(MOVE));
    for (int k = 0; k < 3; k++) tick_alt();
    check("revive no shot", 32'(shots - s0), 32'd0);

    @(negedge clk) bus.enable_i = 1'b0;
    @(negedge clk);
    check("disable state", 32'(bus.ai_state_o), 32'(IDLE));
    check("disable move", 32'(bus.tank_move_o), 32'd0);
    bus.enable_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("enable move", 32'(bus.ai_state_o), 32'(MOVE));
    check("enable onehot", 32'($onehot(bus.tank_move_o)), 32'd1);

    // Asynchronous reset mid-MOVE clears outputs before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async move", 32'(bus.tank_move_o), 32'd0);
    check("async shoot", 32'(bus.tank_shoot_o), 32'd0);
    check("async state", 32'(bus.ai_state_o), 32'(IDLE));
    bus.tank_x_i = 10'd200;
    bus.tank_y_i = 10'd50;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reseed dir", 32'(bus.tank_move_o), 32'(DIR_DOWN));
    run_until_turn(300, 200, n);
    check("expiry frame", 32'(n), 32'd80);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
